// File: rtl/apb_pkg.sv
// Shared APB completer types and default constants.
// The window check lives here so the decode stays a one-liner in the top.
package apb_pkg;

  typedef enum logic {
    ST_S_IDLE   = 1'b0,
    ST_S_ACCESS = 1'b1
  } apb_slave_state_t;

  localparam logic [31:0] APB_BASE_ADDR_DEFAULT = 32'hDEAD_CA00;
  localparam logic [31:0] APB_ID_VALUE_DEFAULT  = 32'hA9B0_0001;

  // Unsigned offset compare; addresses below base wrap to huge offsets and fall out.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [32:0] size_bytes);
    logic [31:0] offset;
    offset = addr - base;
    return ({1'b0, offset} < size_bytes);
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// NUM_REGS x 32-bit register bank: one synchronous write port, one
// combinational read port, asynchronous active-low clear.
module apb_regfile #(
  parameter int NUM_REGS = 64,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer over a register window with fixed wait states and
// pslverr on out-of-window accesses or writes to the read-only ID register.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_S_IDLE   | no transfer in flight; a setup cycle captures the request
//   ST_S_ACCESS | counting wait states, then pready until completion/abort
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = APB_BASE_ADDR_DEFAULT,
  parameter int          NUM_REGS    = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = APB_ID_VALUE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);

  localparam int          IDX_W    = $clog2(NUM_REGS);
  localparam logic [3:0]  WAIT_LD  = 4'(WAIT_CYCLES);
  localparam logic [32:0] WIN_SIZE = 33'(NUM_REGS * 4);

  apb_slave_state_t state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;

  logic [IDX_W-1:0] idx_q;
  logic             write_q;
  logic             err_q;
  logic [31:0]      wdata_q;

  logic [IDX_W-1:0] idx_in;
  logic             in_win;
  logic             err_in;
  logic             capture;
  logic             complete;
  logic             pready;
  logic             rf_we;
  logic [31:0]      rf_rdata;

  assign idx_in = paddr_i[IDX_W+1:2];
  assign in_win = in_window(paddr_i, BASE_ADDR, WIN_SIZE);
  assign err_in = !in_win || (pwrite_i && (idx_in == '0));

  // pready comes only from flops so there is no input-to-output path.
  assign pready = (state_q == ST_S_ACCESS) && (wait_cnt_q == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_S_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    capture    = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_S_IDLE: begin
        if (psel_i && !penable_i) begin
          state_d    = ST_S_ACCESS;
          wait_cnt_d = WAIT_LD;
          capture    = 1'b1;
        end
      end
      ST_S_ACCESS: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
        // Dropping psel mid-transfer abandons it without a response.
        if (!psel_i) begin
          state_d = ST_S_IDLE;
        end else if (penable_i && pready) begin
          complete = 1'b1;
          state_d  = ST_S_IDLE;
        end
      end
      default: state_d = ST_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else if (capture) begin
      idx_q   <= idx_in;
      write_q <= pwrite_i;
      err_q   <= err_in;
      wdata_q <= pwdata_i;
    end
  end

  assign rf_we = complete && write_q && !err_q;

  apb_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (rf_we),
    .waddr   (idx_q),
    .wdata   (wdata_q),
    .raddr   (idx_q),
    .rdata   (rf_rdata)
  );

  assign pready_o  = pready;
  assign pslverr_o = pready && err_q;
  assign prdata_o  = (pready && !write_q && !err_q)
                     ? ((idx_q == '0) ? ID_VALUE : rf_rdata)
                     : 32'h0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: a 2-wait-state instance and a zero-wait instance
// checked against a flat register-array model of the window.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'hDEAD_CA00;
  localparam logic [31:0] ID   = 32'hA9B0_0001;
  localparam int          NREG = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_psel, a_penable, a_pwrite, a_pready, a_pslverr;
  logic [31:0] a_paddr, a_pwdata, a_prdata;
  logic        z_psel, z_penable, z_pwrite, z_pready, z_pslverr;
  logic [31:0] z_paddr, z_pwdata, z_prdata;

  apb_slave_regfile #(
    .BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_CYCLES(2), .ID_VALUE(ID)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .psel_i(a_psel), .penable_i(a_penable),
    .paddr_i(a_paddr), .pwrite_i(a_pwrite), .pwdata_i(a_pwdata),
    .pready_o(a_pready), .prdata_o(a_prdata), .pslverr_o(a_pslverr)
  );

  apb_slave_regfile #(
    .BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_CYCLES(0), .ID_VALUE(ID)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .psel_i(z_psel), .penable_i(z_penable),
    .paddr_i(z_paddr), .pwrite_i(z_pwrite), .pwdata_i(z_pwdata),
    .pready_o(z_pready), .prdata_o(z_prdata), .pslverr_o(z_pslverr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [2][NREG];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + 33'd256));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic drv(input int which, input logic sel, input logic en, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wd);
    if (which == 0) begin
      a_psel = sel; a_penable = en; a_pwrite = wr; a_paddr = addr; a_pwdata = wd;
    end else begin
      z_psel = sel; z_penable = en; z_pwrite = wr; z_paddr = addr; z_pwdata = wd;
    end
  endtask

  task automatic smp(input int which, output logic rdy, output logic err, output logic [31:0] rd);
    if (which == 0) begin
      rdy = a_pready; err = a_pslverr; rd = a_prdata;
    end else begin
      rdy = z_pready; err = z_pslverr; rd = z_prdata;
    end
  endtask

  // Called at a negedge; returns at a negedge with the bus idle, so a following
  // call starts its setup cycle immediately (back-to-back).
  task automatic apb_xfer(input int which, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input bit junk,
                          output logic [31:0] rd, output logic err, output int cyc,
                          output logic stray);
    logic rdy, e;
    logic [31:0] d;
    rd = '0; err = 1'b0; cyc = -1; stray = 1'b0;
    drv(which, 1'b1, 1'b0, wr, addr, wd);
    @(negedge clk);
    drv(which, 1'b1, 1'b1, wr, addr, wd);
    for (int n = 1; n <= 20; n++) begin
      if (junk) drv(which, 1'b1, 1'b1, logic'($urandom_range(0, 1)), $urandom, $urandom);
      smp(which, rdy, e, d);
      if (!rdy && e) stray = 1'b1;
      if (rdy) begin
        rd = d; err = e; cyc = n;
        break;
      end
      @(negedge clk);
    end
    if (cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no pready got 0 expected 1 (addr %h)", addr);
    end
    @(negedge clk);
    drv(which, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic core(input int which, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input bit junk,
                      input logic [31:0] exp_rd, input logic exp_err, input string name);
    logic [31:0] rd;
    logic err, stray;
    int cyc;
    apb_xfer(which, wr, addr, wd, junk, rd, err, cyc, stray);
    chk({name, " pslverr"}, {31'b0, err}, {31'b0, exp_err});
    chk({name, " prdata"}, rd, exp_rd);
    chk({name, " latency"}, 32'(cyc), (which == 0) ? 32'd3 : 32'd1);
    chk({name, " early_err"}, {31'b0, stray}, 32'd0);
    if (wr && !exp_err && cyc > 0) model[which][widx(addr)] = wd;
  endtask

  task automatic do_xfer(input int which, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input bit junk, input string name);
    logic e;
    logic [31:0] r;
    int idx;
    e = !in_win(addr);
    idx = e ? 0 : widx(addr);
    if (!e && wr && idx == 0) e = 1'b1;
    r = (wr || e) ? 32'h0 : ((idx == 0) ? ID : model[which][idx]);
    core(which, wr, addr, wd, junk, r, e, name);
  endtask

  task automatic rand_xfer(input int which);
    logic [31:0] addr;
    case ($urandom_range(0, 3))
      0, 1:    addr = BASE + 32'($urandom_range(0, 255));
      2:       addr = ($urandom_range(0, 1) == 1) ? BASE - 32'($urandom_range(1, 8))
                                                  : BASE + 32'd256 + 32'($urandom_range(0, 7));
      default: addr = $urandom;
    endcase
    do_xfer(which, logic'($urandom_range(0, 1)), addr, $urandom, 1'b1, "rnd");
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < NREG; i++) model[w][i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy, e, seen;
    logic [31:0] d;

    vecs[0]  = '{1'b0, 32'hDEADCAFE, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 32'hDEADCAFE, 32'h00000005, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'hDEADCAFE, 32'h0,        32'h00000005, 1'b0};
    vecs[3]  = '{1'b0, 32'hDEADCAFC, 32'h0,        32'h00000005, 1'b0};
    vecs[4]  = '{1'b1, 32'hDEADCAFE, 32'h00000006, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'hDEADCAFE, 32'h0,        32'h00000006, 1'b0};
    vecs[6]  = '{1'b0, 32'hDEAD0000, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'hDEADCA00, 32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'hDEADCA00, 32'h0,        32'hA9B00001, 1'b0};
    vecs[9]  = '{1'b1, 32'hDEADCB00, 32'h11111111, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'hDEADC9FC, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 32'hDEADCA03, 32'h0,        32'hA9B00001, 1'b0};
    vecs[12] = '{1'b1, 32'hDEADCA04, 32'h0BADBEEF, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'hDEADCA07, 32'h0,        32'h0BADBEEF, 1'b0};
    vecs[14] = '{1'b0, 32'hDEADCB00, 32'h0,        32'h0,        1'b1};

    clear_model();
    drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drv(1, 1'b0, 1'b0, 1'b0, '0, '0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      smp(w, rdy, e, d);
      chk($sformatf("reset%0d pready", w), {31'b0, rdy}, 32'd0);
      chk($sformatf("reset%0d pslverr", w), {31'b0, e}, 32'd0);
      chk($sformatf("reset%0d prdata", w), d, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      core(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
           vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));

    // Zero-wait instance, back-to-back write then read.
    core(1, 1'b1, 32'hDEADCA04, 32'h12345678, 1'b0, 32'h0, 1'b0, "zw_write");
    core(1, 1'b0, 32'hDEADCA04, 32'h0, 1'b0, 32'h12345678, 1'b0, "zw_read");

    // Abort: psel dropped after one access cycle.
    drv(0, 1'b1, 1'b0, 1'b1, 32'hDEADCA08, 32'hCAFEF00D);
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 1'b1, 32'hDEADCA08, 32'hCAFEF00D);
    smp(0, rdy, e, d);
    chk("abort c1 pready", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      smp(0, rdy, e, d);
      if (rdy || e) seen = 1'b1;
    end
    chk("abort no response", {31'b0, seen}, 32'd0);
    core(0, 1'b0, 32'hDEADCA08, 32'h0, 1'b0, 32'h0, 1'b0, "abort readback");

    // Reset during the wait states of a second write.
    core(0, 1'b1, 32'hDEADCA10, 32'h000000AA, 1'b0, 32'h0, 1'b0, "rst_w1");
    core(0, 1'b0, 32'hDEADCA10, 32'h0, 1'b0, 32'h000000AA, 1'b0, "rst_r1");
    drv(0, 1'b1, 1'b0, 1'b1, 32'hDEADCA14, 32'h00000055);
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 1'b1, 32'hDEADCA14, 32'h00000055);
    smp(0, rdy, e, d);
    chk("rst_w2 c1 pready", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 smp(0, rdy, e, d);
    chk("rst_w2 pready", {31'b0, rdy}, 32'd0);
    drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
    clear_model();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset while pready/pslverr are high must drop them before the next edge.
    drv(0, 1'b1, 1'b0, 1'b0, 32'hDEAD0000, 32'h0);
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 1'b0, 32'hDEAD0000, 32'h0);
    for (int n = 0; n < 20; n++) begin
      smp(0, rdy, e, d);
      if (rdy) break;
      @(negedge clk);
    end
    chk("arst pre pready", {31'b0, rdy}, 32'd1);
    chk("arst pre pslverr", {31'b0, e}, 32'd1);
    #2 reset_n = 1'b0;
    #1 smp(0, rdy, e, d);
    chk("arst pready", {31'b0, rdy}, 32'd0);
    chk("arst pslverr", {31'b0, e}, 32'd0);
    drv(0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_xfer(0, 1'b0, 32'hDEADCA10, 32'h0, 1'b0, "post_rst CA10");
    do_xfer(0, 1'b0, 32'hDEADCA14, 32'h0, 1'b0, "post_rst CA14");
    do_xfer(0, 1'b0, 32'hDEADCAFE, 32'h0, 1'b0, "post_rst CAFE");

    for (int i = 0; i < 250; i++) rand_xfer(0);
    for (int i = 0; i < 100; i++) rand_xfer(1);
    for (int i = 0; i < NREG; i++)
      do_xfer(0, 1'b0, BASE + 32'(i * 4), 32'h0, 1'b0, $sformatf("sweep%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
